// File: rtl/fb_fetch_unit_pkg.sv
// Shared types and constants for the Firebird instruction-fetch stage.
//   fb_if_state_e : fetch FSM encodings (IDLE / FETCH / DRAIN)
//   fb_if_entry_t : {pc, inst} record held by the fetch FIFOs
package fb_fetch_unit_pkg;

  localparam int FB_32BITS   = 32;
  localparam int FB_IF_DEPTH = 2;

  typedef enum logic [1:0] {
    FB_IF_IDLE  = 2'd0,
    FB_IF_FETCH = 2'd1,
    FB_IF_DRAIN = 2'd2
  } fb_if_state_e;

  typedef struct packed {
    logic [FB_32BITS-1:0] pc;
    logic [FB_32BITS-1:0] inst;
  } fb_if_entry_t;

endpackage

// File: rtl/fb_fetch_fifo.sv
// 2-entry synchronous FIFO of {pc, inst} records.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (ignored when full unless a pop frees the slot)
//   pop      : drop the head (ignored when empty)
//   clear    : empty the FIFO; any same-cycle pop has already been consumed
//   rdata    : head entry (stale contents when count is 0)
//   count    : number of valid entries, 0..2
module fb_fetch_fifo
  import fb_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fb_if_entry_t wdata,
  output fb_if_entry_t rdata,
  output logic [1:0]   count
);

  fb_if_entry_t mem [FB_IF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'(FB_IF_DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FB_IF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      // A pop in the same cycle was already seen by the consumer, so
      // clearing everything is equivalent to "pop, then clear".
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fb_fetch_unit.sv
// Firebird instruction-fetch stage.
// Holds the word-addressed PC, issues requests to instruction memory,
// pairs in-order responses with their PCs and buffers them in a 2-entry
// FIFO towards decode. Redirects (misprediction) and taken predictions
// flush the stage and discard responses still in flight.
//   clk, rst                       : clock, synchronous active-high reset
//   redirect / redirect_pc         : misprediction and corrected PC
//   pred_valid / pred_pc           : taken prediction from decode
//   imem_req_valid/ready/addr      : request channel (word address)
//   imem_rsp_valid/data            : in-order response channel
//   if_valid / if_pc / if_inst     : FIFO head towards the IF/ID register
//   id_ready                       : IF/ID accepts the head (low = stall)
module fb_fetch_unit
  import fb_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready
);

  fb_if_state_e state;
  logic [31:0]  pc;
  logic [1:0]   outstanding;
  logic [1:0]   drop_cnt;
  logic [1:0]   drop_next;
  logic [1:0]   out_count;
  logic [1:0]   pend_count;
  logic [2:0]   credit_used;
  logic         flush;
  logic         deq;
  logic         hs;
  logic         rsp_live;
  logic         rsp_keep;
  fb_if_entry_t out_head;
  fb_if_entry_t out_wdata;
  fb_if_entry_t pend_head;
  fb_if_entry_t pend_wdata;
  logic         unused_pend;

  assign flush = redirect || pred_valid;
  assign deq   = if_valid && id_ready;

  // Slots already committed: in flight plus buffered. A head leaving this
  // cycle frees its slot immediately, which is what sustains one
  // instruction per cycle with single-cycle memory.
  assign credit_used = {1'b0, outstanding} + {1'b0, out_count} - {2'b0, deq};

  assign imem_req_valid = (state == FB_IF_FETCH) && (credit_used < 3'(FB_IF_DEPTH)) && !flush;
  assign imem_req_addr  = pc;
  assign hs             = imem_req_valid && imem_req_ready;

  // Responses seen in IDLE belong to requests from before reset.
  assign rsp_live = imem_rsp_valid && (state != FB_IF_IDLE);
  assign rsp_keep = rsp_live && (drop_cnt == 2'd0) && !flush;

  always_comb begin
    drop_next = drop_cnt;
    if (flush)
      drop_next = outstanding - {1'b0, rsp_live};
    else if (rsp_live && (drop_cnt != 2'd0))
      drop_next = drop_cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FB_IF_IDLE;
      pc          <= RESET_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      outstanding <= outstanding + {1'b0, hs} - {1'b0, rsp_live};
      drop_cnt    <= drop_next;
      if (flush)   pc <= redirect ? redirect_pc : pred_pc;
      else if (hs) pc <= pc + 32'd1;
      case (state)
        FB_IF_IDLE:  state <= FB_IF_FETCH;
        FB_IF_FETCH: if (flush && (drop_next != 2'd0)) state <= FB_IF_DRAIN;
        FB_IF_DRAIN: if (drop_next == 2'd0) state <= FB_IF_FETCH;
        default:     state <= FB_IF_IDLE;
      endcase
    end
  end

  // PCs of accepted requests, popped as their responses are kept.
  assign pend_wdata = '{pc: pc, inst: 32'h0};

  fb_fetch_fifo u_pend (
    .clk   (clk),
    .rst   (rst),
    .push  (hs),
    .pop   (rsp_keep),
    .clear (flush),
    .wdata (pend_wdata),
    .rdata (pend_head),
    .count (pend_count)
  );

  assign out_wdata = '{pc: pend_head.pc, inst: imem_rsp_data};

  fb_fetch_fifo u_out (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (deq),
    .clear (flush),
    .wdata (out_wdata),
    .rdata (out_head),
    .count (out_count)
  );

  assign unused_pend = ^{pend_head.inst, pend_count};

  assign if_valid = (out_count != 2'd0);
  assign if_pc    = out_head.pc;
  assign if_inst  = out_head.inst;

endmodule

// File: tb/tb_fb_fetch_unit.sv
// Directed bench for fb_fetch_unit with an in-order, fixed-latency memory.
module tb_fb_fetch_unit;
  import fb_fetch_unit_pkg::*;

  localparam logic [31:0] RPC = 32'h40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready = 1'b1;

  always #5 clk = ~clk;

  fb_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .id_ready       (id_ready)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic        idr;
    logic        ev;
    logic [31:0] epc;
    logic        erv;
    logic [31:0] era;
  } vec_t;

  // Start-up, 5-cycle stall and release with single-cycle memory.
  vec_t tbl [15] = '{
    '{1'b1, 1'b0, 32'h00, 1'b0, 32'h40},
    '{1'b1, 1'b0, 32'h00, 1'b1, 32'h40},
    '{1'b1, 1'b0, 32'h00, 1'b1, 32'h41},
    '{1'b1, 1'b1, 32'h40, 1'b1, 32'h42},
    '{1'b1, 1'b1, 32'h41, 1'b1, 32'h43},
    '{1'b1, 1'b1, 32'h42, 1'b1, 32'h44},
    '{1'b0, 1'b1, 32'h43, 1'b0, 32'h45},
    '{1'b0, 1'b1, 32'h43, 1'b0, 32'h45},
    '{1'b0, 1'b1, 32'h43, 1'b0, 32'h45},
    '{1'b0, 1'b1, 32'h43, 1'b0, 32'h45},
    '{1'b0, 1'b1, 32'h43, 1'b0, 32'h45},
    '{1'b1, 1'b1, 32'h43, 1'b1, 32'h45},
    '{1'b1, 1'b1, 32'h44, 1'b1, 32'h46},
    '{1'b1, 1'b1, 32'h45, 1'b1, 32'h47},
    '{1'b1, 1'b1, 32'h46, 1'b1, 32'h48}
  };

  mreq_t       mq[$];
  logic [31:0] deliv[$];
  int          lat = 1;
  int          cyc_no = 0;
  int          passed = 0;
  int          total = 0;
  logic        s_req_valid, s_if_valid;
  logic [31:0] s_req_addr, s_if_pc, s_if_inst;

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // One clock: drive memory response, sample just after inputs settle,
  // then advance the memory model with what happened at the edge.
  task automatic step();
    logic hs_l, rv_l;
    if (mq.size() > 0 && mq[0].due <= cyc_no) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    s_if_pc     = if_pc;
    s_if_inst   = if_inst;
    hs_l = imem_req_valid && imem_req_ready;
    rv_l = imem_rsp_valid;
    @(posedge clk);
    #1;
    if (rst) mq.delete();
    else begin
      if (rv_l) void'(mq.pop_front());
      if (hs_l) mq.push_back('{addr: s_req_addr, due: cyc_no + lat});
      if (s_if_valid && id_ready) deliv.push_back(s_if_pc);
    end
    cyc_no++;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; pred_valid = 1'b0; id_ready = 1'b1;
    step();
    step();
    chk("rst_req_valid", {31'b0, s_req_valid}, 32'd0);
    chk("rst_req_addr",  s_req_addr, RPC);
    chk("rst_if_valid",  {31'b0, s_if_valid}, 32'd0);
    chk("rst_if_pc",     s_if_pc, 32'd0);
    chk("rst_if_inst",   s_if_inst, 32'd0);
    rst = 1'b0;
    cyc_no = 0;
    deliv.delete();
  endtask

  initial begin
    // ---- start-up, stall, release ----
    lat = 1;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      id_ready = tbl[k].idr;
      step();
      chk($sformatf("t%0d_req_valid", k), {31'b0, s_req_valid}, {31'b0, tbl[k].erv});
      chk($sformatf("t%0d_req_addr", k), s_req_addr, tbl[k].era);
      chk($sformatf("t%0d_if_valid", k), {31'b0, s_if_valid}, {31'b0, tbl[k].ev});
      if (tbl[k].ev) begin
        chk($sformatf("t%0d_if_pc", k), s_if_pc, tbl[k].epc);
        chk($sformatf("t%0d_if_inst", k), s_if_inst, inst_of(tbl[k].epc));
      end
    end
    chk("stall_deliv_cnt", deliv.size(), 32'd7);
    for (int i = 0; i < 7 && i < deliv.size(); i++)
      chk($sformatf("stall_deliv%0d", i), deliv[i], RPC + 32'(i));

    // ---- latency 3, redirect with 2 outstanding ----
    lat = 3;
    do_reset();
    step(); step(); step();
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("drn_flush_req", {31'b0, s_req_valid}, 32'd0);
    chk("drn_state", {31'b0, dut.state == FB_IF_DRAIN}, 32'd1);
    for (int k = 4; k < 6; k++) begin
      step();
      chk($sformatf("drn%0d_req_valid", k), {31'b0, s_req_valid}, 32'd0);
      chk($sformatf("drn%0d_if_valid", k), {31'b0, s_if_valid}, 32'd0);
    end
    step();
    chk("drn_first_req_valid", {31'b0, s_req_valid}, 32'd1);
    chk("drn_first_req_addr", s_req_addr, 32'h100);
    step(); step(); step();
    chk("drn_k9_if_valid", {31'b0, s_if_valid}, 32'd0);
    step();
    chk("drn_first_if_valid", {31'b0, s_if_valid}, 32'd1);
    chk("drn_first_if_pc", s_if_pc, 32'h100);
    chk("drn_deliv_cnt", deliv.size(), 32'd1);

    // ---- reset while in DRAIN ----
    lat = 3;
    do_reset();
    step(); step(); step();
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    step();
    chk("rd_in_drain", {31'b0, dut.state == FB_IF_DRAIN}, 32'd1);
    rst = 1'b1;
    step();
    chk("rd_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rd_req_addr", imem_req_addr, RPC);
    chk("rd_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rd_if_pc", if_pc, 32'd0);
    chk("rd_if_inst", if_inst, 32'd0);
    rst = 1'b0; cyc_no = 0; lat = 1; deliv.delete();
    step(); step();
    chk("rd_restart_addr", s_req_addr, RPC);
    chk("rd_restart_valid", {31'b0, s_req_valid}, 32'd1);
    step(); step();
    chk("rd_restart_if_pc", s_if_pc, RPC);

    // ---- redirect and prediction in the same cycle ----
    lat = 1;
    do_reset();
    step();
    redirect = 1'b1; redirect_pc = 32'h200; pred_valid = 1'b1; pred_pc = 32'h300;
    step();
    redirect = 1'b0; pred_valid = 1'b0;
    chk("prio_flush_req", {31'b0, s_req_valid}, 32'd0);
    step();
    chk("prio_req_addr", s_req_addr, 32'h200);
    chk("prio_req_valid", {31'b0, s_req_valid}, 32'd1);
    step(); step();
    chk("prio_if_pc", s_if_pc, 32'h200);

    // ---- redirect coincident with response and decode pop ----
    lat = 1;
    do_reset();
    step(); step(); step(); step();
    redirect = 1'b1; redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    chk("co_pop_valid", {31'b0, s_if_valid}, 32'd1);
    chk("co_pop_pc", s_if_pc, 32'h41);
    step();
    chk("co_empty", {31'b0, s_if_valid}, 32'd0);
    chk("co_req_addr", s_req_addr, 32'h80);
    step(); step();
    chk("co_new_pc", s_if_pc, 32'h80);
    chk("co_deliv_cnt", deliv.size(), 32'd3);
    if (deliv.size() == 3) begin
      chk("co_deliv0", deliv[0], 32'h40);
      chk("co_deliv1", deliv[1], 32'h41);
      chk("co_deliv2", deliv[2], 32'h80);
    end

    // ---- PC wraps modulo 2^32 ----
    lat = 1;
    do_reset();
    step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    step();
    chk("wrap_addr0", s_req_addr, 32'hFFFF_FFFF);
    step();
    chk("wrap_addr1", s_req_addr, 32'h0);
    step();
    chk("wrap_if_pc0", s_if_pc, 32'hFFFF_FFFF);
    chk("wrap_if_inst0", s_if_inst, 32'hC0DE_FFFF);
    step();
    chk("wrap_if_pc1", s_if_pc, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
